// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor.
// Computes diff = a - b - bin LSB-first through one full-subtractor cell and a
// borrow flip-flop, one bit per clock, behind a start/busy/done handshake.
// Results stay registered until the operation after the next accepted start
// completes.

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  // Bit counter only has to reach WIDTH-1; keep at least one bit.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fsub(input logic x, input logic y, input logic br);
    logic d;
    logic bo;
    d  = x ^ y ^ br;
    bo = (~x & y) | (~(x ^ y) & br);
    return {bo, d};
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;

  logic [1:0]       cell_s;
  logic             accept_s;
  logic             last_s;

  // Current bit through the subtractor cell, plus handshake decode.
  always_comb begin
    cell_s   = fsub(a_sr_r[0], b_sr_r[0], br_r);
    accept_s = 1'b0;
    last_s   = 1'b0;
    if (state_r == SHIFT) begin
      last_s = (cnt_r == CNT_LAST);
    end else begin
      accept_s = start;
    end
  end

  // Next-state logic: start is honoured only from IDLE or DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (accept_s) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register with registered busy/done flags decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == SHIFT);
      done_r  <= (state_s == DONE);
    end
  end

  // Operand capture, serial shifting and result loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_r  <= {WIDTH{1'b0}};
      b_sr_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      diff_r  <= {WIDTH{1'b0}};
      bout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            br_r    <= bin;
            cnt_r   <= {CW{1'b0}};
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
          end
        end
        SHIFT: begin
          a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
          res_r  <= {cell_s[0], res_r[WIDTH-1:1]};
          br_r   <= cell_s[1];
          if (last_s) begin
            // Final bit: publish the full result; counter holds at WIDTH-1.
            diff_r <= {cell_s[0], res_r[WIDTH-1:1]};
            bout_r <= cell_s[1];
            ovf_r  <= (a_msb_r ^ b_msb_r) & (cell_s[0] ^ a_msb_r);
          end else begin
            cnt_r  <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          br_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) with a result scoreboard.

module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ov;
  } exp_t;

  exp_t sb[$];
  exp_t exp_prev;
  int   n_vec;
  int   n_err;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model: 9-bit arithmetic subtraction.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [8:0] r;
    exp_t e;
    r    = {1'b0, x} - {1'b0, y} - {8'd0, bi};
    e.d  = r[7:0];
    e.bo = r[8];
    e.ov = (x[7] != y[7]) && (r[7] != x[7]);
    return e;
  endfunction

  // Scoreboard: pop and compare on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      check("busy_with_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e.d});
        check("bout", {31'd0, bout}, {31'd0, e.bo});
        check("ovf",  {31'd0, ovf},  {31'd0, e.ov});
      end
    end
  end

  // One operation: one-cycle start, optional ignored start pulse mid-flight.
  task automatic run_op(input logic [7:0] x, input logic [7:0] y, input logic bi,
                        input bit poke);
    int lat;
    exp_t e;
    e = model(x, y, bi);
    @(negedge clk);
    start = 1'b1; a = x; b = y; bin = bi;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin
        check("diff_hold", {24'd0, diff}, {24'd0, exp_prev.d});
        if (poke) begin
          start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b0;
        end
      end
      if (lat == 4) start = 1'b0;
    end
    check("latency", lat, 32'd8);
    exp_prev = e;
    @(posedge clk); #1;
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    n_vec = 0; n_err = 0;
    exp_prev = '0;
    start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'h00, 8'h01, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b0);
    run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
    run_op(8'h10, 8'h0F, 1'b1, 1'b0);
    // Start pulse during busy must be ignored.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b1);
    check("after_poke_diff", {24'd0, diff}, 32'h1E);

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h44; bin = 1'b1;
    sb.push_back(model(8'h33, 8'h44, 1'b1));
    @(posedge clk); #1;
    a = 8'h90; b = 8'h20; bin = 1'b0;
    sb.push_back(model(8'h90, 8'h20, 1'b0));
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat1", lat, 32'd8);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat2", lat, 32'd8);
    exp_prev = model(8'h90, 8'h20, 1'b0);
    @(posedge clk); #1;

    // Reset mid-operation: aborts with outputs cleared, no done.
    @(negedge clk);
    start = 1'b1; a = 8'hC3; b = 8'h11; bin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'd0);
    check("abort_bout", {31'd0, bout}, 32'd0);
    check("abort_ovf",  {31'd0, ovf},  32'd0);
    repeat (10) begin
      @(posedge clk); #1;
      check("abort_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_prev = '0;
    run_op(8'h05, 8'h03, 1'b0, 1'b0);
    check("fresh_diff", {24'd0, diff}, 32'h02);

    // Random vectors.
    for (int i = 0; i < 20; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
